// File: rtl/apu_pkg.sv
// Shared APU constants: register map, field positions and the length/duty lookup tables.
package apu_pkg;

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_SWEEP = 2'd1;
  localparam logic [1:0] ADDR_PLO   = 2'd2;
  localparam logic [1:0] ADDR_PHI   = 2'd3;

  localparam int CTRL_DUTY_LSB = 6;
  localparam int CTRL_HALT     = 5;
  localparam int CTRL_CONST    = 4;
  localparam int SWEEP_EN      = 7;
  localparam int SWEEP_PER_LSB = 4;
  localparam int SWEEP_NEG     = 3;
  localparam int LEN_IDX_LSB   = 3;

  localparam logic [7:0] LENGTH_TABLE [0:31] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

  localparam logic [7:0] DUTY_TABLE [0:3] = '{
    8'b01000000, 8'b01100000, 8'b01111000, 8'b10011111
  };

endpackage

// File: rtl/pulse_channel_if.sv
// CPU-side register write port of an APU voice.
interface pulse_channel_if;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/apu_envelope.sv
// Quarter-frame envelope: start flag, divider and 4-bit decay level with optional loop.
module apu_envelope (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       qfr_stb,
  input  logic       start_set,
  input  logic       loop,
  input  logic [3:0] env_period,
  output logic [3:0] decay
);

  logic       start;
  logic [3:0] div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start <= 1'b0;
      div   <= '0;
      decay <= '0;
    end else begin
      // a start raised on a quarter-frame edge is consumed by the following quarter-frame
      start <= start_set | (start & ~qfr_stb);
      if (qfr_stb) begin
        if (start) begin
          decay <= 4'd15;
          div   <= env_period;
        end else if (div == 4'd0) begin
          div <= env_period;
          if (decay != 4'd0)
            decay <= decay - 4'd1;
          else if (loop)
            decay <= 4'd15;
        end else begin
          div <= div - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/pulse_channel.sv
// APU pulse voice: period timer, duty sequencer, envelope, sweep unit and length counter.
module pulse_channel
  import apu_pkg::*;
#(
  parameter int CHANNEL = 1,
  parameter int TIMER_W = 11,
  parameter int OUT_W   = 16
) (
  input  logic                    in_apu_clk,
  input  logic                    in_rst_n,
  input  logic                    in_qfr_stb,
  input  logic                    in_hfr_stb,
  input  logic                    in_enable,
  pulse_channel_if.slave          bus,
  output logic signed [OUT_W-1:0] pulse_out,
  output logic                    len_active
);

  logic [7:0]              ctrl_reg, sweep_reg;
  logic [TIMER_W-1:0]      period, timer;
  logic [2:0]              step, sw_div;
  logic                    sw_reload;
  logic [7:0]              length;
  logic [3:0]              decay, volume;
  logic [TIMER_W:0]        delta, target;
  logic                    mute, sweep_hit;
  logic                    wr_ctrl, wr_sweep, wr_plo, wr_phi;
  logic signed [OUT_W-1:0] sample_p1;

  function automatic logic signed [OUT_W-1:0] sample_level(input logic level_hi,
                                                            input logic [3:0] level);
    logic signed [OUT_W-1:0] mag;
    mag = '0;
    mag[OUT_W-3 -: 4] = level;
    return level_hi ? mag : -mag;
  endfunction

  assign wr_ctrl  = bus.wr_en && (bus.wr_addr == ADDR_CTRL);
  assign wr_sweep = bus.wr_en && (bus.wr_addr == ADDR_SWEEP);
  assign wr_plo   = bus.wr_en && (bus.wr_addr == ADDR_PLO);
  assign wr_phi   = bus.wr_en && (bus.wr_addr == ADDR_PHI);

  // Sweep target and mute are live every cycle, whether or not the sweep is enabled.
  always_comb begin
    delta = {1'b0, period} >> sweep_reg[2:0];
    if (!sweep_reg[SWEEP_NEG])
      target = {1'b0, period} + delta;
    else if (CHANNEL == 1)
      target = {1'b0, period} - delta - 1'b1;
    else
      target = {1'b0, period} - delta;
    mute = (period < TIMER_W'(8)) || (!sweep_reg[SWEEP_NEG] && target[TIMER_W]);
  end

  assign sweep_hit = in_hfr_stb && (sw_div == 3'd0) && sweep_reg[SWEEP_EN] &&
                     (sweep_reg[2:0] != 3'd0) && !mute;
  assign volume    = ctrl_reg[CTRL_CONST] ? ctrl_reg[3:0] : decay;

  apu_envelope u_env (
    .clk        (in_apu_clk),
    .rst_n      (in_rst_n),
    .qfr_stb    (in_qfr_stb),
    .start_set  (wr_phi),
    .loop       (ctrl_reg[CTRL_HALT]),
    .env_period (ctrl_reg[3:0]),
    .decay      (decay)
  );

  always_ff @(posedge in_apu_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      ctrl_reg  <= '0;
      sweep_reg <= '0;
      period    <= '0;
      timer     <= '0;
      step      <= '0;
      sw_div    <= '0;
      sw_reload <= 1'b0;
      length    <= '0;
      sample_p1 <= '0;
    end else begin
      if (wr_ctrl)  ctrl_reg  <= bus.wr_data;
      if (wr_sweep) sweep_reg <= bus.wr_data;

      // CPU period writes take precedence over a same-edge sweep adjustment
      if (wr_plo)
        period[7:0] <= bus.wr_data;
      else if (wr_phi)
        period[TIMER_W-1:8] <= bus.wr_data[TIMER_W-9:0];
      else if (sweep_hit)
        period <= target[TIMER_W-1:0];

      if (in_hfr_stb) begin
        if (sw_div == 3'd0 || sw_reload)
          sw_div <= sweep_reg[SWEEP_PER_LSB +: 3];
        else
          sw_div <= sw_div - 3'd1;
      end
      if (wr_sweep)
        sw_reload <= 1'b1;
      else if (in_hfr_stb)
        sw_reload <= 1'b0;

      if (timer == '0) begin
        timer <= period;
        step  <= step - 3'd1;
      end else begin
        timer <= timer - 1'b1;
      end
      if (wr_phi) step <= 3'd0;

      if (!in_enable)
        length <= '0;
      else if (wr_phi)
        length <= LENGTH_TABLE[bus.wr_data[7:LEN_IDX_LSB]];
      else if (in_hfr_stb && !ctrl_reg[CTRL_HALT] && length != 8'd0)
        length <= length - 8'd1;

      // output stage: one cycle behind the sequencer state
      if (length == 8'd0 || mute)
        sample_p1 <= '0;
      else
        sample_p1 <= sample_level(DUTY_TABLE[ctrl_reg[CTRL_DUTY_LSB +: 2]][step], volume);
    end
  end

  assign pulse_out  = sample_p1;
  assign len_active = (length != 8'd0);

endmodule

// File: tb/tb_pulse_channel.sv
// Bench for pulse_channel: two voices (CHANNEL 1 and 2) against an integer reference model.
module tb_pulse_channel;
  localparam int OUT_W = 16;
  localparam int SCALE = 1 << (OUT_W - 6);

  logic clk = 1'b0;
  logic rst_n, qfr, hfr, en;
  logic signed [OUT_W-1:0] out1, out2;
  logic act1, act2;
  int checks = 0;
  int errors = 0;

  pulse_channel_if bus_if ();

  pulse_channel #(.CHANNEL(1), .TIMER_W(11), .OUT_W(OUT_W)) u_ch1 (
    .in_apu_clk(clk), .in_rst_n(rst_n), .in_qfr_stb(qfr), .in_hfr_stb(hfr),
    .in_enable(en), .bus(bus_if), .pulse_out(out1), .len_active(act1));
  pulse_channel #(.CHANNEL(2), .TIMER_W(11), .OUT_W(OUT_W)) u_ch2 (
    .in_apu_clk(clk), .in_rst_n(rst_n), .in_qfr_stb(qfr), .in_hfr_stb(hfr),
    .in_enable(en), .bus(bus_if), .pulse_out(out2), .len_active(act2));

  always #5 clk = ~clk;

  int LEN_TAB [32] = '{10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,
                       12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30};
  int DUTY_PAT [4] = '{'h40, 'h60, 'h78, 'h9F};

  typedef struct {
    int r0, r1, period, timer, step;
    int decay, env_div, env_start;
    int sw_div, sw_reload, length;
  } chan_t;
  chan_t m [2];
  int exp_out [2];
  int exp_act [2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m[c] = '{default: 0};
      exp_out[c] = 0;
      exp_act[c] = 0;
    end
  endtask

  // One clock edge of voice c, computed from the register-level rules.
  task automatic model_step(input int c);
    chan_t o, n;
    int shift, neg, delta, target, mute, vol, lvl;
    o = m[c];
    n = o;
    shift  = o.r1 & 7;
    neg    = (o.r1 >> 3) & 1;
    delta  = o.period >> shift;
    target = neg ? (o.period - delta - (c == 0 ? 1 : 0)) : (o.period + delta);
    mute   = (o.period < 8 || (!neg && target > 2047)) ? 1 : 0;
    vol    = ((o.r0 >> 4) & 1) ? (o.r0 & 15) : o.decay;
    lvl    = (DUTY_PAT[(o.r0 >> 6) & 3] >> o.step) & 1;
    exp_out[c] = (o.length == 0 || mute) ? 0 : (lvl ? vol * SCALE : -vol * SCALE);

    if (o.timer == 0) begin
      n.timer = o.period;
      n.step  = (o.step + 7) % 8;
    end else begin
      n.timer = o.timer - 1;
    end

    if (qfr) begin
      n.env_start = 0;
      if (o.env_start) begin
        n.decay = 15; n.env_div = o.r0 & 15;
      end else if (o.env_div == 0) begin
        n.env_div = o.r0 & 15;
        if (o.decay > 0) n.decay = o.decay - 1;
        else if ((o.r0 >> 5) & 1) n.decay = 15;
      end else begin
        n.env_div = o.env_div - 1;
      end
    end

    if (hfr) begin
      if (o.sw_div == 0 && ((o.r1 >> 7) & 1) && shift != 0 && !mute) n.period = target;
      n.sw_div    = (o.sw_div == 0 || o.sw_reload) ? ((o.r1 >> 4) & 7) : o.sw_div - 1;
      n.sw_reload = 0;
      if (!((o.r0 >> 5) & 1) && o.length > 0) n.length = o.length - 1;
    end

    if (bus_if.wr_en) begin
      case (int'(bus_if.wr_addr))
        0: n.r0 = bus_if.wr_data;
        1: begin n.r1 = bus_if.wr_data; n.sw_reload = 1; end
        2: n.period = (o.period & 'h700) | bus_if.wr_data;
        default: begin
          n.period    = ((bus_if.wr_data & 7) << 8) | (o.period & 'hFF);
          n.step      = 0;
          n.env_start = 1;
          if (en) n.length = LEN_TAB[bus_if.wr_data >> 3];
        end
      endcase
    end
    if (!en) n.length = 0;

    m[c] = n;
    exp_act[c] = (n.length != 0) ? 1 : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else for (int c = 0; c < 2; c++) model_step(c);
    chk("pulse_out_ch1", int'(out1), exp_out[0]);
    chk("pulse_out_ch2", int'(out2), exp_out[1]);
    chk("len_active_ch1", int'(act1), exp_act[0]);
    chk("len_active_ch2", int'(act2), exp_act[1]);
  endtask

  task automatic wr(input int a, input int d);
    bus_if.wr_en = 1'b1; bus_if.wr_addr = 2'(a); bus_if.wr_data = 8'(d);
    tick();
    bus_if.wr_en = 1'b0;
  endtask

  task automatic strobe(input bit half);
    qfr = 1'b1; hfr = half;
    tick();
    qfr = 1'b0; hfr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  function automatic int sample_of(input int w);
    return (w == 0) ? int'(out1) : int'(out2);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Length of one full positive run of the square wave, plus the levels seen.
  task automatic measure(input int w, output int hi_len, output int hi_val, output int lo_val);
    int g;
    hi_len = 0;
    g = 0;
    while (sample_of(w) >= 0 && g < 6000) begin tick(); g++; end
    lo_val = sample_of(w);
    g = 0;
    while (sample_of(w) <= 0 && g < 6000) begin tick(); g++; end
    hi_val = sample_of(w);
    while (sample_of(w) > 0 && hi_len < 6000) begin tick(); hi_len++; end
  endtask

  initial begin
    int hl, hv, lv;
    rst_n = 1'b0; qfr = 1'b0; hfr = 1'b0; en = 1'b1;
    bus_if.wr_en = 1'b0; bus_if.wr_addr = 2'd0; bus_if.wr_data = 8'd0;
    model_reset();
    repeat (3) tick();
    chk("reset_out", int'(out1), 0);
    chk("reset_act", int'(act1), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 50% duty, constant volume 15, period 253
    wr(0, 'hBF); wr(2, 'hFD); wr(3, 'h08);
    chk("t1_active", int'(act1), 1);
    measure(0, hl, hv, lv);
    chk("t1_high_run", hl, 8 * 254 / 2);
    chk("t1_high_level", hv, 15360);
    chk("t1_low_level", lv, -15360);

    // envelope decay, no loop, then with loop
    do_reset();
    wr(0, 'h07); wr(2, 'hFD); wr(3, 'h08);
    strobe(0);
    chk("t2_env_start", iabs(int'(out1)), 15 * 1024);
    repeat (64) strobe(0);
    chk("t2_env_mid", iabs(int'(out1)), 7 * 1024);
    repeat (56) strobe(0);
    chk("t2_env_zero", int'(out1), 0);
    repeat (8) strobe(0);
    chk("t2_env_noloop", int'(out1), 0);
    wr(0, 'h27); wr(3, 'h08);
    repeat (121) strobe(0);
    chk("t2_loop_zero", int'(out1), 0);
    repeat (8) strobe(0);
    chk("t2_loop_wrap", iabs(int'(out1)), 15 * 1024);

    // length countdown and enable clear
    do_reset();
    wr(0, 'h9F); wr(2, 'hFD); wr(3, 'h08);
    repeat (253) strobe(1);
    chk("t3_len_253", int'(act1), 1);
    strobe(1);
    chk("t3_len_254", int'(act1), 0);
    wr(3, 'h08);
    repeat (10) strobe(1);
    en = 1'b0;
    tick();
    chk("t3_disable", int'(act1), 0);
    wr(3, 'h08);
    chk("t3_load_disabled", int'(act1), 0);
    en = 1'b1;
    tick();

    // sweep negate: ones' versus two's complement
    do_reset();
    wr(0, 'hBF); wr(2, 'h00); wr(3, 'h09); wr(1, 'h89);
    strobe(1);
    chk("t4_model_p1", m[0].period, 'h7F);
    chk("t4_model_p2", m[1].period, 'h80);
    measure(0, hl, hv, lv);
    chk("t4_ch1_run", hl, 4 * ('h7F + 1));
    measure(1, hl, hv, lv);
    chk("t4_ch2_run", hl, 4 * ('h80 + 1));

    // sweep add overflow mutes
    do_reset();
    wr(0, 'hBF); wr(2, 'h00); wr(3, 'h0F); wr(1, 'h81);
    repeat (4) tick();
    chk("t4_mute_out", int'(out1), 0);
    strobe(1);
    chk("t4_mute_out2", int'(out2), 0);
    chk("t4_mute_period", m[0].period, 'h700);
    chk("t4_mute_active", int'(act1), 1);

    // length load beats a coincident half-frame decrement
    do_reset();
    wr(0, 'h9F); wr(2, 'hFD); wr(3, 'h08);
    repeat (5) strobe(1);
    qfr = 1'b1; hfr = 1'b1;
    wr(3, 'h08);
    qfr = 1'b0; hfr = 1'b0;
    chk("t5_model_len", m[0].length, 254);
    chk("t5_model_step", m[0].step, 0);
    repeat (253) strobe(1);
    chk("t5_len_253", int'(act2), 1);
    strobe(1);
    chk("t5_len_254", int'(act2), 0);

    // asynchronous reset mid-tone
    do_reset();
    wr(0, 'hBF); wr(2, 'hFD); wr(3, 'h08);
    repeat (300) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_out", int'(out1), 0);
    chk("t6_async_act", int'(act2), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (50) tick();
    chk("t6_silent", int'(out1), 0);
    wr(3, 'h08);
    chk("t6_reload", int'(act1), 1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      qfr = ($urandom_range(0, 11) == 0);
      hfr = qfr && ($urandom_range(0, 1) == 1);
      en  = ($urandom_range(0, 99) != 0);
      bus_if.wr_en   = ($urandom_range(0, 7) == 0);
      bus_if.wr_addr = 2'($urandom_range(0, 3));
      bus_if.wr_data = 8'($urandom_range(0, 255));
      tick();
    end
    qfr = 1'b0; hfr = 1'b0; en = 1'b1; bus_if.wr_en = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
